// File: rtl/morse_pkg.sv
// Shared definitions for the Morse key sequencer.
//   state_t     : sequencer states (IDLE, PRESS, GAP, LETTER)
//   MAX_SYMBOLS : default symbol register depth
//   SYM_W       : symbol register width
//   DOT / DASH  : symbol encoding inside the symbol register
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESS  = 2'd1,
    GAP    = 2'd2,
    LETTER = 2'd3
  } state_t;

  localparam int MAX_SYMBOLS = 5;
  localparam int SYM_W       = 5;

  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;

endpackage

// File: rtl/morse_tick_gen.sv
// Timing tick prescaler for the Morse key sequencer.
// Counts 0..TICK_DIV-1 and flags the last count as a tick.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset
//   clear : synchronous restart of the count at 0
//   tick  : high while the count equals TICK_DIV-1
module morse_tick_gen #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/morse_key_sequencer.sv
// Morse key sequencer: times the key button, classifies each press as a
// dot or dash, detects the inter-letter gap and hands a completed letter
// (symbol bits plus count) downstream with a one-cycle strobe.
// Single clock, tick based; key timing no longer clocks any logic.
// Ports:
//   clk          : system clock
//   reset        : synchronous active-high reset
//   enable       : sequencer enable; low forces IDLE and drops the letter
//   key_in       : raw key button (asynchronous)
//   sym_valid    : one-cycle pulse per classified symbol
//   sym_is_dash  : class of the last symbol (valid with sym_valid)
//   sym_count    : symbols stored in the current letter
//   sym_bits     : symbol register, 1 = dash, latest symbol in bit 0
//   letter_valid : one-cycle pulse while the finished letter is presented
//   overflow     : more than MAX_SYMBOLS presses in the current letter
//   busy         : sequencer not in IDLE
module morse_key_sequencer #(
  parameter int unsigned TICK_DIV    = 4,
  parameter int unsigned DASH_TICKS  = 3,
  parameter int unsigned GAP_TICKS   = 5,
  parameter int unsigned MAX_SYMBOLS = morse_pkg::MAX_SYMBOLS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        key_in,
  output logic                        sym_valid,
  output logic                        sym_is_dash,
  output logic [2:0]                  sym_count,
  output logic [morse_pkg::SYM_W-1:0] sym_bits,
  output logic                        letter_valid,
  output logic                        overflow,
  output logic                        busy
);

  import morse_pkg::*;

  localparam logic [7:0] DASH_T  = 8'(DASH_TICKS);
  localparam logic [7:0] GAP_T   = 8'(GAP_TICKS);
  localparam logic [7:0] DUR_MAX = 8'hFF;
  localparam logic [2:0] MAX_CNT = 3'(MAX_SYMBOLS);

  // Synchronizer
  logic sync1;
  logic key_s;

  // FSM and datapath state
  state_t             state;
  state_t             state_d;
  logic [7:0]         dur;
  logic [7:0]         dur_d;
  logic [7:0]         dur_inc;
  logic               tick;
  logic               tick_clr;
  logic               is_dash;

  // Next values of the registered outputs
  logic               sym_valid_d;
  logic               sym_is_dash_d;
  logic [2:0]         sym_count_d;
  logic [SYM_W-1:0]   sym_bits_d;
  logic               letter_valid_d;
  logic               overflow_d;

  morse_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clear(tick_clr),
    .tick (tick)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state, next outputs, duration counter control
  always_comb begin
    state_d        = state;
    sym_valid_d    = 1'b0;
    sym_is_dash_d  = sym_is_dash;
    sym_count_d    = sym_count;
    sym_bits_d     = sym_bits;
    letter_valid_d = 1'b0;
    overflow_d     = overflow;
    is_dash        = (dur >= DASH_T) ? DASH : DOT;
    dur_inc        = (dur == DUR_MAX) ? dur : dur + 8'd1;

    if (!enable) begin
      state_d     = IDLE;
      sym_count_d = '0;
      sym_bits_d  = '0;
      overflow_d  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (key_s) begin
            state_d = PRESS;
          end
        end
        PRESS: begin
          if (!key_s) begin
            sym_valid_d   = 1'b1;
            sym_is_dash_d = is_dash;
            if (sym_count < MAX_CNT) begin
              sym_bits_d  = {sym_bits[SYM_W-2:0], is_dash};
              sym_count_d = sym_count + 3'd1;
            end else begin
              overflow_d = 1'b1;
            end
            state_d = GAP;
          end
        end
        GAP: begin
          // A re-press beats a gap that completes in the same cycle.
          if (key_s) begin
            state_d = PRESS;
          end else if (tick && (dur_inc >= GAP_T)) begin
            state_d        = LETTER;
            letter_valid_d = 1'b1;
          end
        end
        LETTER: begin
          state_d     = IDLE;
          sym_count_d = '0;
          sym_bits_d  = '0;
          overflow_d  = 1'b0;
        end
      endcase
    end

    tick_clr = !enable || (state_d != state);

    if (tick_clr) begin
      dur_d = '0;
    end else if (tick && ((state == PRESS) || (state == GAP))) begin
      dur_d = dur_inc;
    end else begin
      dur_d = dur;
    end
  end

  // Synchronizer, duration counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1        <= 1'b0;
      key_s        <= 1'b0;
      dur          <= '0;
      sym_valid    <= 1'b0;
      sym_is_dash  <= 1'b0;
      sym_count    <= '0;
      sym_bits     <= '0;
      letter_valid <= 1'b0;
      overflow     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      sync1        <= key_in;
      key_s        <= sync1;
      dur          <= dur_d;
      sym_valid    <= sym_valid_d;
      sym_is_dash  <= sym_is_dash_d;
      sym_count    <= sym_count_d;
      sym_bits     <= sym_bits_d;
      letter_valid <= letter_valid_d;
      overflow     <= overflow_d;
      busy         <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Self-checking bench for morse_key_sequencer. Key activity is described as
// a list of (high cycles, low cycles) segments; a behavioural model turns
// that list into the expected timeline of symbol, letter and post-letter
// clear events, which is compared against what the DUT produced.
module tb_morse_key_sequencer;

  localparam int TICK_DIV   = 4;
  localparam int DASH_TICKS = 3;
  localparam int GAP_TICKS  = 5;
  localparam int MAX_SYM    = 5;
  localparam int GAP_CYC    = GAP_TICKS * TICK_DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       key_in;
  logic       sym_valid;
  logic       sym_is_dash;
  logic [2:0] sym_count;
  logic [4:0] sym_bits;
  logic       letter_valid;
  logic       overflow;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int base   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int          seg_h[$];
  int          seg_l[$];
  logic        prev_lv = 1'b0;

  morse_key_sequencer #(
    .TICK_DIV   (TICK_DIV),
    .DASH_TICKS (DASH_TICKS),
    .GAP_TICKS  (GAP_TICKS),
    .MAX_SYMBOLS(MAX_SYM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .key_in      (key_in),
    .sym_valid   (sym_valid),
    .sym_is_dash (sym_is_dash),
    .sym_count   (sym_count),
    .sym_bits    (sym_bits),
    .letter_valid(letter_valid),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event word: kind(1=symbol,2=letter,3=cycle after letter), cycle relative
  // to the first key press, dash (busy for kind 3), overflow, count, bits.
  function automatic logic [31:0] mk(input logic [1:0] k, input int rel,
                                     input logic a, input logic o,
                                     input int n, input int b);
    return {k, rel[19:0], a, o, n[2:0], b[4:0]};
  endfunction

  always @(negedge clk) begin
    if (sym_valid)
      obs_q.push_back(mk(2'd1, cyc - base, sym_is_dash, overflow, int'(sym_count), int'(sym_bits)));
    if (letter_valid)
      obs_q.push_back(mk(2'd2, cyc - base, 1'b0, overflow, int'(sym_count), int'(sym_bits)));
    if (prev_lv)
      obs_q.push_back(mk(2'd3, cyc - base, busy, overflow, int'(sym_count), int'(sym_bits)));
    prev_lv <= letter_valid;
  end

  // Model: a press held H cycles is seen for H-1 cycles before the release
  // is sampled, so it lasts (H-1)/TICK_DIV whole ticks. The symbol shows 3
  // cycles after the fall; a low period longer than GAP_CYC closes the
  // letter GAP_CYC+3 cycles after the fall. Letters keep the first MAX_SYM
  // symbols, oldest in the most significant position.
  task automatic play();
    int   t;
    int   f;
    int   n;
    int   bv;
    logic o;
    logic d;
    exp_q.delete();
    t  = 0;
    n  = 0;
    bv = 0;
    o  = 1'b0;
    for (int i = 0; i < seg_h.size(); i++) begin
      f = t + seg_h[i];
      d = (((seg_h[i] - 1) / TICK_DIV) >= DASH_TICKS);
      if (n < MAX_SYM) begin
        bv = bv * 2 + int'(d);
        n  = n + 1;
      end else begin
        o = 1'b1;
      end
      exp_q.push_back(mk(2'd1, f + 3, d, o, n, bv));
      if (seg_l[i] > GAP_CYC) begin
        exp_q.push_back(mk(2'd2, f + GAP_CYC + 3, 1'b0, o, n, bv));
        exp_q.push_back(mk(2'd3, f + GAP_CYC + 4, 1'b0, 1'b0, 0, 0));
        n  = 0;
        bv = 0;
        o  = 1'b0;
      end
      t = f + seg_l[i];
    end
    @(negedge clk);
    obs_q.delete();
    base = cyc;
    for (int i = 0; i < seg_h.size(); i++) begin
      key_in = 1'b1;
      repeat (seg_h[i]) @(negedge clk);
      key_in = 1'b0;
      repeat (seg_l[i]) @(negedge clk);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b1;
    key_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (sym_valid !== 1'b0)    begin errors++; $display("FAIL reset sym_valid: got %b required 0", sym_valid); end
    checks++; if (sym_is_dash !== 1'b0)  begin errors++; $display("FAIL reset sym_is_dash: got %b required 0", sym_is_dash); end
    checks++; if (sym_count !== 3'd0)    begin errors++; $display("FAIL reset sym_count: got %0d required 0", sym_count); end
    checks++; if (sym_bits !== 5'd0)     begin errors++; $display("FAIL reset sym_bits: got %b required 00000", sym_bits); end
    checks++; if (letter_valid !== 1'b0) begin errors++; $display("FAIL reset letter_valid: got %b required 0", letter_valid); end
    checks++; if (overflow !== 1'b0)     begin errors++; $display("FAIL reset overflow: got %b required 0", overflow); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL reset busy: got %b required 0", busy); end
  endtask

  task automatic test_letter_a();
    seg_h = '{5, 17};
    seg_l = '{4, 24};
    play();
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL letter_a events: got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL letter_a ev%0d: got %h required %h", i, (i < obs_q.size()) ? obs_q[i] : 32'hx, exp_q[i]);
      end
    end
  endtask

  task automatic test_threshold();
    seg_h = '{9, 12, 13};
    seg_l = '{30, 30, 30};
    play();
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL threshold events: got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL threshold ev%0d: got %h required %h", i, (i < obs_q.size()) ? obs_q[i] : 32'hx, exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    seg_h = '{5, 5, 5, 5, 5, 5};
    seg_l = '{4, 4, 4, 4, 4, 30};
    play();
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL overflow events: got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL overflow ev%0d: got %h required %h", i, (i < obs_q.size()) ? obs_q[i] : 32'hx, exp_q[i]);
      end
    end
  endtask

  // Low for exactly GAP_CYC cycles: the re-press lands on the closing cycle.
  task automatic test_gap_race();
    seg_h = '{5, 5};
    seg_l = '{GAP_CYC, 30};
    play();
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL gap_race events: got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL gap_race ev%0d: got %h required %h", i, (i < obs_q.size()) ? obs_q[i] : 32'hx, exp_q[i]);
      end
    end
  endtask

  task automatic test_abort(input bit use_reset);
    @(negedge clk);
    key_in = 1'b1; repeat (5) @(negedge clk);
    key_in = 1'b0; repeat (4) @(negedge clk);
    key_in = 1'b1; repeat (5) @(negedge clk);
    key_in = 1'b0; repeat (8) @(negedge clk);
    checks++; if (sym_count !== 3'd2) begin errors++; $display("FAIL abort%0d pre sym_count: got %0d required 2", use_reset, sym_count); end
    checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL abort%0d pre busy: got %b required 1", use_reset, busy); end
    if (use_reset) reset = 1'b1;
    else           enable = 1'b0;
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b1;
    checks++; if (sym_count !== 3'd0) begin errors++; $display("FAIL abort%0d sym_count: got %0d required 0", use_reset, sym_count); end
    checks++; if (sym_bits !== 5'd0)  begin errors++; $display("FAIL abort%0d sym_bits: got %b required 00000", use_reset, sym_bits); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL abort%0d busy: got %b required 0", use_reset, busy); end
    obs_q.delete();
    repeat (40) @(negedge clk);
    checks++; if (obs_q.size() != 0)  begin errors++; $display("FAIL abort%0d later events: got %0d required 0", use_reset, obs_q.size()); end
  endtask

  // A single-cycle key pulse is always captured by the synchronizer here,
  // so it must give one zero-tick dot and then a one-symbol letter.
  task automatic test_glitch();
    seg_h = '{1};
    seg_l = '{30};
    play();
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL glitch events: got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL glitch ev%0d: got %h required %h", i, (i < obs_q.size()) ? obs_q[i] : 32'hx, exp_q[i]);
      end
    end
  endtask

  // Low periods of exactly GAP_CYC+1 are avoided: the re-press then meets
  // the LETTER cycle and starts one cycle late, which the model ignores.
  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      seg_h.delete();
      seg_l.delete();
      for (int i = 0; i < 10; i++) begin
        seg_h.push_back(int'($urandom_range(1, 24)));
        if (i == 9)                          seg_l.push_back(26);
        else if ($urandom_range(0, 3) == 0)  seg_l.push_back(int'($urandom_range(GAP_CYC + 2, GAP_CYC + 10)));
        else                                 seg_l.push_back(int'($urandom_range(1, GAP_CYC)));
      end
      play();
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL random%0d events: got %0d required %0d", r, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL random%0d ev%0d: got %h required %h", r, i, (i < obs_q.size()) ? obs_q[i] : 32'hx, exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_letter_a();
    test_threshold();
    test_overflow();
    test_gap_race();
    test_abort(1'b1);
    test_abort(1'b0);
    test_glitch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no end of run, required end before time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/morse_key_sequencer.md
# morse_key_sequencer

Control block for the Morse decoder datapath. Times the key button, classifies each press as dot or dash, and detects the inter-letter gap. It accumulates up to five symbols into a symbol register and hands a completed letter (bits plus count) to the translate and seven-segment stage with a one-cycle strobe. It replaces ad-hoc button-clocked counting with a single-clock, tick-based sequencer.

## Interface
Parameters:
- TICK_DIV, 4: `clk` cycles per timing tick; must be ≥ 2.
- DASH_TICKS, 3: a press lasting ≥ DASH_TICKS ticks is a dash; otherwise it is a dot.
- GAP_TICKS, 5: released ticks that close a letter.
- MAX_SYMBOLS, 5: symbol register depth.

Ports:
- clk, in, 1: system clock; the only clock.
- reset, in, 1: synchronous, active-high; reset is synchronous and active-high.
- enable, in, 1: sequencer enable; 0 forces IDLE.
- key_in, in, 1: raw key button; asynchronous.
- sym_valid, out, 1: one-cycle pulse per classified symbol.
- sym_is_dash, out, 1: class of the last symbol; valid when sym_valid=1.
- sym_count, out, 3: symbols stored in the current letter (0..5).
- sym_bits, out, 5: symbol register; 1 = dash, 0 = dot. The latest symbol is in bit 0.
- letter_valid, out, 1: one-cycle pulse when a letter closes.
- overflow, out, 1: more than MAX_SYMBOLS presses occurred in the current letter.
- busy, out, 1: high whenever state ≠ IDLE.

## Operation
- key_in passes through a 2-FF synchronizer to produce key_s. All decisions use key_s.
- A tick prescaler counts 0..TICK_DIV-1. It asserts tick when the count equals TICK_DIV-1 and restarts at 0 on every state change.
- The duration counter is 8 bits and saturates at 255. It is used for both press length and gap length and is cleared on every state change.
- States and transitions:
  - IDLE: if key_s=1, go to PRESS.
  - PRESS: each tick increments dur. When key_s=0:
    - Classify: dash if dur ≥ DASH_TICKS, else dot.
    - Pulse sym_valid and drive sym_is_dash.
    - If sym_count < MAX_SYMBOLS: sym_bits ← {sym_bits[3:0], is_dash} and sym_count increments. Otherwise leave the register unchanged and set overflow.
    - Go to GAP.
  - GAP: each tick increments dur. key_s=1 goes to PRESS (same letter). If dur reaches GAP_TICKS, go to LETTER.
  - LETTER: lasts exactly one cycle. letter_valid=1, and sym_bits, sym_count and overflow hold the finished letter. Next cycle: state goes to IDLE, and sym_bits, sym_count and overflow clear to 0.
- A press of 0 ticks (release before the first tick) is still a dot.
- Simultaneous events:
  - In GAP, key_s=1 in the same cycle dur reaches GAP_TICKS: the press wins, the state goes to PRESS and the letter stays open.
  - enable=0 has priority over everything except reset. The state goes to IDLE; the prescaler, dur, sym_bits, sym_count and overflow clear; no pulses are issued and the partial letter is discarded.
- overflow is sticky within a letter and clears only after LETTER, on enable=0 or on reset.

## Timing
- Reset values: state IDLE; every output is 0; synchronizer, prescaler and dur are 0.
- All outputs are registered.
- key_in edge to key_s: 2 cycles.
- State change: 1 cycle after the key_s edge.
- sym_valid: asserted the cycle after key_s is first sampled 0 in PRESS, i.e. 3 cycles after the key_in fall.
- sym_bits and sym_count update in the same cycle as sym_valid.
- A press held P·TICK_DIV cycles in PRESS gives dur = P.
- letter_valid: the GAP_TICKS·TICK_DIV-th cycle in GAP causes the transition, and letter_valid is high in the following cycle.
- Reset mid-letter: the next cycle shows reset values; no letter_valid is emitted.

## Structure
- Package morse_pkg holds:
  - the state enum (IDLE, PRESS, GAP, LETTER);
  - MAX_SYMBOLS and SYM_W = 5;
  - the symbol encoding constants DOT = 0, DASH = 1.
- Sub-module morse_tick_gen: the prescaler with a synchronous clear input and a tick output.
- Synchronizer, FSM, duration counter and symbol register stay in the top level.

## Test plan
- Dot-dash letter "A": press 1 tick, gap 1 tick, press 4 ticks, release 6 ticks. Required: two sym_valid pulses (is_dash 0, then 1), then letter_valid with sym_bits=5'b00001 and sym_count=2, then all clear.
- Threshold: press exactly 2 ticks gives a dot; press exactly 3 ticks gives a dash (DASH_TICKS=3).
- Overflow: 6 dots in one letter. Required: 6 sym_valid pulses, sym_count stays 5, overflow=1, letter_valid with sym_bits=5'b00000; overflow then clears.
- Gap race: re-press in the exact cycle dur reaches 5. Required: no letter_valid, state PRESS, sym_count is retained.
- Reset and enable mid-letter: after 2 symbols, pulse reset for 1 cycle. Required: sym_count=0, busy=0, and no letter_valid afterwards. Repeat with enable=0 for 1 cycle and require the same result.
- Glitch: key_in high for 1 cycle while in IDLE. Required: behaviour matches the synchronizer; if captured, one dot with dur=0, otherwise no activity.
